axil_triple_write_fsm: RTL and testbench
========================================

Name: axil_triple_write_fsm

Overview:
- Responder on the loop controller's start/done interface.
- On each accepted start, latches the 5-bit iteration index and issues exactly three sequential AXI4-Lite single-beat writes (AW/W/B channels) derived from that index.
- Pulses done after the third write response, and flags any non-OKAY response.
- Sits between the loop controller and the AXI-Lite interconnect; read channels are out of scope.

Parameters:
- ADDR_WIDTH, 32, width of m_axi_awaddr.
- BASE_ADDR, 32'h0000_1000, byte address of write 0 for index 0.
- DATA_TAG, 16'hA5C3, constant placed in WDATA[31:16].

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_three_writes  input  1  start request; sampled only in IDLE.
- i_m1_val  input  5  iteration index; latched when start is accepted.
- three_writes_done  output  1  one-cycle pulse when all three B responses have been received.
- busy  output  1  high in any state other than IDLE.
- wr_error  output  1  sticky; set on any BRESP != 2'b00; cleared on next start acceptance.
- m_axi_awvalid / m_axi_awready  output/input  1  AW handshake.
- m_axi_awaddr  output  ADDR_WIDTH  write address.
- m_axi_awprot  output  3  constant 3'b000.
- m_axi_wvalid / m_axi_wready  output/input  1  W handshake.
- m_axi_wdata  output  32  write data.
- m_axi_wstrb  output  4  constant 4'hF.
- m_axi_bvalid  input  1  write response valid.
- m_axi_bready  output  1  write response ready.
- m_axi_bresp  input  2  write response code.

Behaviour:
- Clock/reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: state IDLE, write index k=0, latched index=0; all valid/ready outputs, three_writes_done, busy and wr_error are 0; awaddr/wdata are 0. Reset mid-transaction abandons it immediately; no completion of the outstanding write is attempted.
- States: IDLE, ADDR_DATA, RESP, DONE.
- IDLE:
  - start_three_writes=1 → latch i_m1_val into idx, set k=0, clear wr_error, go ADDR_DATA.
  - Start while not IDLE is ignored (no queueing).
- ADDR_DATA:
  - awvalid and wvalid asserted (registered, first high the cycle after entry decision).
  - awaddr = BASE_ADDR + ((idx*4 + k) << 2).
  - wdata = {DATA_TAG, 3'b0, idx, 6'b0, k[1:0]}.
  - AW and W handshake independently. Each valid drops the cycle after its own handshake, and address/data stay stable while valid. Internal aw_done/w_done flags track completion.
  - Go RESP when both are done; both completing in the same cycle is allowed.
- RESP:
  - bready=1 (only in this state).
  - On bvalid&bready: if bresp != 0, set wr_error.
  - If k<2: k++, go ADDR_DATA.
  - If k==2: go DONE.
- DONE: three_writes_done=1 for exactly one cycle; go IDLE. A start in the DONE cycle is ignored; start is next accepted in IDLE.
- Error handling: errors do not abort the sequence; all three writes are always issued.
- Arithmetic: address math is done at ADDR_WIDTH with zero-extension, wrap-around modulo 2^ADDR_WIDTH. idx values 24..31 are accepted without range check.
- Latency with always-ready slave and bvalid one cycle after the W handshake: start sampled at cycle N → AW/W handshakes at N+1, N+3, N+5; B handshakes at N+2, N+4, N+6; done pulse at N+7.
- No combinational path from any AXI input to any AXI output.

Test Plan:
- Always-ready slave, start with i_m1_val=5 at cycle N:
  - AW handshakes at N+1/N+3/N+5 with addresses 0x1050/0x1054/0x1058.
  - wdata 0xA5C3_0500/0501/0502.
  - done at N+7 only; wr_error=0.
- awready delayed 3 cycles while wready is immediate:
  - wvalid drops after its handshake; awvalid/awaddr held stable.
  - RESP entered only after the AW handshake; exactly three writes issued.
- Second write returns bresp=2'b10:
  - wr_error rises and stays 1; third write still issued; done pulses.
  - Next start clears wr_error.
- Start pulsed repeatedly while busy and in the DONE cycle, with i_m1_val changing: ignored; addresses use the originally latched idx.
- i_m1_val=31: third address 0x11F8, wdata 0xA5C3_1F02.
- rst_n asserted while awvalid=1 mid-sequence: all outputs 0 immediately; IDLE after release; a new start gives a correct full sequence.

Source files
------------

// File: rtl/axil_triple_write_fsm.sv
// axil_triple_write_fsm
//   Responder on the loop controller's start/done handshake. Each accepted
//   start latches a 5-bit iteration index and issues three back-to-back
//   AXI4-Lite single-beat writes derived from it. three_writes_done pulses once
//   after the third B response. wr_error is sticky for any non-OKAY response.
//
// Ports
//   clk, rst_n             clock (rising edge) / async active-low reset
//   start_three_writes     start request, only looked at in IDLE
//   i_m1_val[4:0]          iteration index, latched on start acceptance
//   three_writes_done      one-cycle completion pulse
//   busy                   high whenever the FSM is not IDLE
//   wr_error               sticky non-OKAY BRESP flag, cleared on next start
//   m_axi_aw*/w*/b*        AXI4-Lite write channels (master side)
module axil_triple_write_fsm #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [15:0]           DATA_TAG   = 16'hA5C3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_three_writes,
  input  logic [4:0]            i_m1_val,
  output logic                  three_writes_done,
  output logic                  busy,
  output logic                  wr_error,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_DATA = 2'd1,
    S_RESP      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                r_state,    w_state_nxt;
  logic [4:0]            r_idx,      w_idx_nxt;
  logic [1:0]            r_k,        w_k_nxt;
  logic                  r_awvalid,  w_awvalid_nxt;
  logic                  r_wvalid,   w_wvalid_nxt;
  logic                  r_aw_done,  w_aw_done_nxt;
  logic                  r_w_done,   w_w_done_nxt;
  logic                  r_wr_error, w_wr_error_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr,   w_awaddr_nxt;
  logic [31:0]           r_wdata,    w_wdata_nxt;

  // Write k of index idx lands at BASE_ADDR + ((idx*4 + k) << 2); the offset
  // is zero-extended and the sum wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] f_awaddr(input logic [4:0] idx,
                                                     input logic [1:0] k);
    logic [ADDR_WIDTH-1:0] v_off;
    v_off      = '0;
    v_off[8:0] = {idx, k, 2'b00};
    return BASE_ADDR + v_off;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [4:0] idx,
                                          input logic [1:0] k);
    return {DATA_TAG, 3'b000, idx, 6'b00_0000, k};
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_k_nxt        = r_k;
    w_awvalid_nxt  = r_awvalid;
    w_wvalid_nxt   = r_wvalid;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_wr_error_nxt = r_wr_error;
    w_awaddr_nxt   = r_awaddr;
    w_wdata_nxt    = r_wdata;

    unique case (r_state)
      S_IDLE: begin
        if (start_three_writes) begin
          w_idx_nxt      = i_m1_val;
          w_k_nxt        = 2'd0;
          w_wr_error_nxt = 1'b0;
          w_awaddr_nxt   = f_awaddr(i_m1_val, 2'd0);
          w_wdata_nxt    = f_wdata(i_m1_val, 2'd0);
          w_awvalid_nxt  = 1'b1;
          w_wvalid_nxt   = 1'b1;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_state_nxt    = S_ADDR_DATA;
        end
      end

      S_ADDR_DATA: begin
        // AW and W complete independently; each valid drops right after its
        // own handshake while address/data registers are left untouched.
        w_aw_done_nxt = r_aw_done | (r_awvalid & m_axi_awready);
        w_w_done_nxt  = r_w_done  | (r_wvalid  & m_axi_wready);
        w_awvalid_nxt = r_awvalid & ~m_axi_awready;
        w_wvalid_nxt  = r_wvalid  & ~m_axi_wready;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        // bready is high for the whole of this state, so bvalid alone marks
        // the B handshake.
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            w_wr_error_nxt = 1'b1;
          end
          if (r_k < 2'd2) begin
            w_k_nxt       = r_k + 2'd1;
            w_awaddr_nxt  = f_awaddr(r_idx, r_k + 2'd1);
            w_wdata_nxt   = f_wdata(r_idx, r_k + 2'd1);
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_state_nxt   = S_ADDR_DATA;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        // A start seen here is deliberately dropped.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_k        <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wr_error <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_k        <= w_k_nxt;
      r_awvalid  <= w_awvalid_nxt;
      r_wvalid   <= w_wvalid_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_wr_error <= w_wr_error_nxt;
      r_awaddr   <= w_awaddr_nxt;
      r_wdata    <= w_wdata_nxt;
    end
  end

  // All outputs come straight from registers or the state register, so no
  // AXI input reaches an AXI output combinationally.
  assign m_axi_awvalid     = r_awvalid;
  assign m_axi_awaddr      = r_awaddr;
  assign m_axi_awprot      = 3'b000;
  assign m_axi_wvalid      = r_wvalid;
  assign m_axi_wdata       = r_wdata;
  assign m_axi_wstrb       = 4'hF;
  assign m_axi_bready      = (r_state == S_RESP);
  assign three_writes_done = (r_state == S_DONE);
  assign busy              = (r_state != S_IDLE);
  assign wr_error          = r_wr_error;

endmodule

// File: tb/tb_axil_triple_write_fsm.sv
// tb_axil_triple_write_fsm
//   Table of directed write sequences (index, slave ready delays, BRESP per
//   write, expected addresses/data/error/timing) applied in a loop against a
//   small AXI-Lite slave model, plus hand-written sequences for ignored
//   starts and reset in the middle of a transfer.
module tb_axil_triple_write_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_three_writes = 1'b0;
  logic [4:0]  i_m1_val = '0;
  logic        three_writes_done;
  logic        busy;
  logic        wr_error;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;

  axil_triple_write_fsm dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_three_writes (start_three_writes),
    .i_m1_val           (i_m1_val),
    .three_writes_done  (three_writes_done),
    .busy               (busy),
    .wr_error           (wr_error),
    .m_axi_awvalid      (m_axi_awvalid),
    .m_axi_awready      (m_axi_awready),
    .m_axi_awaddr       (m_axi_awaddr),
    .m_axi_awprot       (m_axi_awprot),
    .m_axi_wvalid       (m_axi_wvalid),
    .m_axi_wready       (m_axi_wready),
    .m_axi_wdata        (m_axi_wdata),
    .m_axi_wstrb        (m_axi_wstrb),
    .m_axi_bvalid       (m_axi_bvalid),
    .m_axi_bready       (m_axi_bready),
    .m_axi_bresp        (m_axi_bresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        idx;
    int                aw_dly;
    int                w_dly;
    logic [2:0][1:0]   resp;      // resp[k] returned for write k
    logic [2:0][31:0]  addr;      // addr[k] expected for write k
    logic [2:0][31:0]  data;
    logic              err;
    int                aw0_off;   // cycles from start sample to AW #0
    int                b0_off;    // cycles from start sample to B #0
    int                period;    // cycles between successive writes
    int                done_off;  // cycles from start sample to done sample
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Slave model state
  int               aw_dly = 0;
  int               w_dly = 0;
  logic [2:0][1:0]  resp_tab = '0;
  int               aw_cnt, w_cnt, n_b, viol;
  bit               aw_pend, w_pend, b_fire;
  bit               p_awvalid, p_wvalid, p_aw_fire, p_w_fire;
  logic [31:0]      p_awaddr, p_wdata;
  logic [31:0]      aw_addr_q[$];
  logic [31:0]      w_data_q[$];
  int               aw_cyc_q[$];
  int               b_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI-Lite slave: programmable AW/W ready delays, B one cycle after both
  // AW and W have handshaken. Also watches valid stability and that bready
  // never overlaps an outstanding AW/W. Handshakes are logged with the cycle
  // number of the rising edge on which they complete.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      aw_cnt = 0; w_cnt = 0;
      aw_pend = 0; w_pend = 0; b_fire = 0;
      p_awvalid = 0; p_wvalid = 0; p_aw_fire = 0; p_w_fire = 0;
      p_awaddr = '0; p_wdata = '0;
    end else begin
      if (p_awvalid && !p_aw_fire && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
      if (p_wvalid && !p_w_fire && (!m_axi_wvalid || m_axi_wdata != p_wdata)) viol++;
      if (p_aw_fire && m_axi_awvalid) viol++;
      if (p_w_fire && m_axi_wvalid) viol++;
      if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) viol++;

      if (b_fire) begin
        m_axi_bvalid = 1'b0;
        b_fire = 0;
      end
      if (aw_pend && w_pend && !m_axi_bvalid) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (n_b < 3) ? resp_tab[n_b] : 2'b00;
        aw_pend = 0;
        w_pend  = 0;
      end

      m_axi_awready = 1'b0;
      p_aw_fire = 0;
      if (m_axi_awvalid) begin
        if (aw_cnt >= aw_dly) begin
          m_axi_awready = 1'b1;
          aw_addr_q.push_back(m_axi_awaddr);
          aw_cyc_q.push_back(cyc + 1);
          aw_pend = 1; aw_cnt = 0; p_aw_fire = 1;
        end else aw_cnt++;
      end
      m_axi_wready = 1'b0;
      p_w_fire = 0;
      if (m_axi_wvalid) begin
        if (w_cnt >= w_dly) begin
          m_axi_wready = 1'b1;
          w_data_q.push_back(m_axi_wdata);
          w_pend = 1; w_cnt = 0; p_w_fire = 1;
        end else w_cnt++;
      end

      if (m_axi_bvalid && m_axi_bready) begin
        b_fire = 1;
        b_cyc_q.push_back(cyc + 1);
        n_b++;
      end
      p_awvalid = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_wvalid  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
    end
  end

  task automatic clear_logs();
    aw_addr_q.delete(); w_data_q.delete();
    aw_cyc_q.delete();  b_cyc_q.delete();
    n_b = 0; viol = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'(0));
    check({tag, "_wvalid"},  64'(m_axi_wvalid),  64'(0));
    check({tag, "_bready"},  64'(m_axi_bready),  64'(0));
    check({tag, "_done"},    64'(three_writes_done), 64'(0));
    check({tag, "_busy"},    64'(busy),          64'(0));
    check({tag, "_wr_error"},64'(wr_error),      64'(0));
    check({tag, "_awaddr"},  64'(m_axi_awaddr),  64'(0));
    check({tag, "_wdata"},   64'(m_axi_wdata),   64'(0));
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    int n0, t, extra, done_at;
    logic err_at_done;
    aw_dly = v.aw_dly; w_dly = v.w_dly; resp_tab = v.resp;
    clear_logs();
    @(negedge clk);
    start_three_writes = 1'b1;
    i_m1_val = v.idx;
    n0 = cyc + 1;
    @(negedge clk);
    start_three_writes = 1'b0;
    i_m1_val = ~v.idx;  // latched index must not follow the input
    check({tag, "_busy_start"},  64'(busy), 64'(1));
    check({tag, "_err_cleared"}, 64'(wr_error), 64'(0));
    check({tag, "_awvalid_start"}, 64'(m_axi_awvalid), 64'(1));
    check({tag, "_wvalid_start"},  64'(m_axi_wvalid), 64'(1));
    check({tag, "_awprot"}, 64'(m_axi_awprot), 64'(0));
    check({tag, "_wstrb"},  64'(m_axi_wstrb), 64'(4'hF));
    t = 0;
    while (!three_writes_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 64'(three_writes_done), 64'(1));
    done_at = cyc + 1;
    err_at_done = wr_error;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (three_writes_done) extra++;
    end
    check({tag, "_done_once"}, 64'(extra), 64'(0));
    check({tag, "_done_off"}, 64'(done_at - n0), 64'(v.done_off));
    check({tag, "_err_at_done"}, 64'(err_at_done), 64'(v.err));
    check({tag, "_err_sticky"}, 64'(wr_error), 64'(v.err));
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check({tag, "_n_aw"}, 64'(aw_addr_q.size()), 64'(3));
    check({tag, "_n_w"},  64'(w_data_q.size()), 64'(3));
    check({tag, "_n_b"},  64'(n_b), 64'(3));
    check({tag, "_viol"}, 64'(viol), 64'(0));
    for (int k = 0; k < 3; k++) begin
      if (k < aw_addr_q.size()) begin
        check($sformatf("%s_awaddr%0d", tag, k), 64'(aw_addr_q[k]), 64'(v.addr[k]));
        check($sformatf("%s_aw_off%0d", tag, k), 64'(aw_cyc_q[k] - n0),
              64'(v.aw0_off + k * v.period));
      end
      if (k < w_data_q.size())
        check($sformatf("%s_wdata%0d", tag, k), 64'(w_data_q[k]), 64'(v.data[k]));
      if (k < b_cyc_q.size())
        check($sformatf("%s_b_off%0d", tag, k), 64'(b_cyc_q[k] - n0),
              64'(v.b0_off + k * v.period));
    end
  endtask

  vec_t vecs[7];

  initial begin
    int t, n_done;
    vecs[0] = '{idx: 5'd5, aw_dly: 0, w_dly: 0, resp: {2'b00, 2'b00, 2'b00},
                addr: {32'h1058, 32'h1054, 32'h1050},
                data: {32'hA5C3_0502, 32'hA5C3_0501, 32'hA5C3_0500},
                err: 1'b0, aw0_off: 1, b0_off: 2, period: 2, done_off: 7};
    vecs[1] = '{idx: 5'd5, aw_dly: 3, w_dly: 0, resp: {2'b00, 2'b00, 2'b00},
                addr: {32'h1058, 32'h1054, 32'h1050},
                data: {32'hA5C3_0502, 32'hA5C3_0501, 32'hA5C3_0500},
                err: 1'b0, aw0_off: 4, b0_off: 5, period: 5, done_off: 16};
    vecs[2] = '{idx: 5'd10, aw_dly: 0, w_dly: 0, resp: {2'b00, 2'b10, 2'b00},
                addr: {32'h10A8, 32'h10A4, 32'h10A0},
                data: {32'hA5C3_0A02, 32'hA5C3_0A01, 32'hA5C3_0A00},
                err: 1'b1, aw0_off: 1, b0_off: 2, period: 2, done_off: 7};
    vecs[3] = '{idx: 5'd31, aw_dly: 1, w_dly: 2, resp: {2'b00, 2'b00, 2'b00},
                addr: {32'h11F8, 32'h11F4, 32'h11F0},
                data: {32'hA5C3_1F02, 32'hA5C3_1F01, 32'hA5C3_1F00},
                err: 1'b0, aw0_off: 2, b0_off: 4, period: 4, done_off: 13};
    vecs[4] = '{idx: 5'd0, aw_dly: 0, w_dly: 0, resp: {2'b00, 2'b00, 2'b11},
                addr: {32'h1008, 32'h1004, 32'h1000},
                data: {32'hA5C3_0002, 32'hA5C3_0001, 32'hA5C3_0000},
                err: 1'b1, aw0_off: 1, b0_off: 2, period: 2, done_off: 7};
    vecs[5] = '{idx: 5'd24, aw_dly: 0, w_dly: 0, resp: {2'b00, 2'b00, 2'b00},
                addr: {32'h1188, 32'h1184, 32'h1180},
                data: {32'hA5C3_1802, 32'hA5C3_1801, 32'hA5C3_1800},
                err: 1'b0, aw0_off: 1, b0_off: 2, period: 2, done_off: 7};
    vecs[6] = '{idx: 5'd9, aw_dly: 0, w_dly: 0, resp: {2'b00, 2'b00, 2'b00},
                addr: {32'h1098, 32'h1094, 32'h1090},
                data: {32'hA5C3_0902, 32'hA5C3_0901, 32'hA5C3_0900},
                err: 1'b0, aw0_off: 1, b0_off: 2, period: 2, done_off: 7};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 6; i++) run_seq(vecs[i], $sformatf("v%0d", i));

    // Starts pulsed while busy and in the DONE cycle, index changing.
    aw_dly = 0; w_dly = 0; resp_tab = '0;
    clear_logs();
    @(negedge clk);
    start_three_writes = 1'b1;
    i_m1_val = 5'd7;
    t = 0; n_done = 0;
    while (t < 100) begin
      @(negedge clk);
      start_three_writes = 1'b1;
      i_m1_val = 5'((t * 3) + 1);
      t++;
      if (three_writes_done) begin
        n_done++;
        break;
      end
    end
    check("ign_done_seen", 64'(n_done), 64'(1));
    @(negedge clk);
    start_three_writes = 1'b0;
    check("ign_idle_after_done", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("ign_still_idle", 64'(busy), 64'(0));
    check("ign_n_aw", 64'(aw_addr_q.size()), 64'(3));
    check("ign_n_b", 64'(n_b), 64'(3));
    if (aw_addr_q.size() == 3) begin
      check("ign_awaddr0", 64'(aw_addr_q[0]), 64'(32'h1070));
      check("ign_awaddr1", 64'(aw_addr_q[1]), 64'(32'h1074));
      check("ign_awaddr2", 64'(aw_addr_q[2]), 64'(32'h1078));
      check("ign_wdata2",  64'(w_data_q[2]),  64'(32'hA5C3_0702));
    end

    // Reset while awvalid is waiting on a slow slave.
    aw_dly = 3;
    clear_logs();
    @(negedge clk);
    start_three_writes = 1'b1;
    i_m1_val = 5'd9;
    @(negedge clk);
    start_three_writes = 1'b0;
    @(negedge clk);
    check("rst_mid_awvalid", 64'(m_axi_awvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", 64'(busy), 64'(0));
    run_seq(vecs[6], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
